// File: rtl/debug_mem_engine.sv
// Debug memory access engine: turns register-block write strobes and address
// changes into single-outstanding memory requests with timeout and sticky status.
module debug_mem_engine #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] debug_mem_addr,
    input  logic [31:0] debug_mem_data,
    input  logic        debug_mem_write_access,
    input  logic        i_status_clr,
    output logic [31:0] debug_mem_status,
    output logic [31:0] virt_debug_mem_data,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_REQ = 2'd1,
        RD_REQ = 2'd2
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] rdback_q, rdback_d;
    logic        pw_valid_q, pw_valid_d;
    logic [31:0] pw_addr_q, pw_addr_d;
    logic [31:0] pw_data_q, pw_data_d;
    logic        rd_pend_q, rd_pend_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;
    logic        overflow_q, overflow_d;
    logic [7:0]  op_cnt_q, op_cnt_d;
    logic [15:0] to_cnt_q, to_cnt_d;

    logic        rd_pend_any;
    logic        launch;
    logic        set_timeout;
    logic        set_overflow;

    always_comb begin
        state_d      = state_q;
        addr_d       = debug_mem_addr;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rdback_d     = rdback_q;
        pw_valid_d   = pw_valid_q;
        pw_addr_d    = pw_addr_q;
        pw_data_d    = pw_data_q;
        op_cnt_d     = op_cnt_q;
        to_cnt_d     = to_cnt_q;
        done_d       = done_q;
        launch       = 1'b0;
        set_timeout  = 1'b0;
        set_overflow = 1'b0;

        // A change seen this cycle counts as a pending read straight away.
        rd_pend_any = rd_pend_q | (debug_mem_addr != addr_q);
        rd_pend_d   = rd_pend_any;

        case (state_q)
            IDLE: begin
                if (debug_mem_write_access) begin
                    state_d     = WR_REQ;
                    mem_addr_d  = debug_mem_addr;
                    mem_wdata_d = debug_mem_data;
                    launch      = 1'b1;
                end else if (pw_valid_q) begin
                    state_d     = WR_REQ;
                    mem_addr_d  = pw_addr_q;
                    mem_wdata_d = pw_data_q;
                    pw_valid_d  = 1'b0;
                    launch      = 1'b1;
                end else if (rd_pend_any) begin
                    state_d    = RD_REQ;
                    mem_addr_d = debug_mem_addr;
                    rd_pend_d  = 1'b0;
                    launch     = 1'b1;
                end
            end
            WR_REQ, RD_REQ: begin
                if (debug_mem_write_access) begin
                    if (!pw_valid_q) begin
                        pw_valid_d = 1'b1;
                        pw_addr_d  = debug_mem_addr;
                        pw_data_d  = debug_mem_data;
                    end else begin
                        set_overflow = 1'b1;
                    end
                end
                // Ack beats a coincident timeout.
                if (i_mem_ack) begin
                    state_d  = IDLE;
                    rdback_d = (state_q == RD_REQ) ? i_mem_rdata : mem_wdata_q;
                    done_d   = 1'b1;
                    op_cnt_d = op_cnt_q + 8'd1;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d     = IDLE;
                    set_timeout = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (launch) begin
            to_cnt_d = 16'd0;
            done_d   = 1'b0;
        end

        timeout_d  = set_timeout  | (timeout_q  & ~i_status_clr);
        overflow_d = set_overflow | (overflow_q & ~i_status_clr);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            addr_q      <= debug_mem_addr;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            rdback_q    <= 32'd0;
            pw_valid_q  <= 1'b0;
            pw_addr_q   <= 32'd0;
            pw_data_q   <= 32'd0;
            rd_pend_q   <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            overflow_q  <= 1'b0;
            op_cnt_q    <= 8'd0;
            to_cnt_q    <= 16'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdback_q    <= rdback_d;
            pw_valid_q  <= pw_valid_d;
            pw_addr_q   <= pw_addr_d;
            pw_data_q   <= pw_data_d;
            rd_pend_q   <= rd_pend_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            overflow_q  <= overflow_d;
            op_cnt_q    <= op_cnt_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    assign o_mem_req           = (state_q != IDLE);
    assign o_mem_we            = (state_q == WR_REQ);
    assign o_mem_addr          = mem_addr_q;
    assign o_mem_wdata         = mem_wdata_q;
    assign virt_debug_mem_data = rdback_q;
    assign debug_mem_status    = {16'h0000, op_cnt_q, 2'b00, rd_pend_q, pw_valid_q,
                                  overflow_q, timeout_q, done_q, o_mem_req};

endmodule

// File: tb/tb_debug_mem_engine.sv
// Bench for debug_mem_engine: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_debug_mem_engine;

    localparam int TO = 8;

    logic        i_clk;
    logic        i_rst_n;
    logic [31:0] debug_mem_addr;
    logic [31:0] debug_mem_data;
    logic        debug_mem_write_access;
    logic        i_status_clr;
    logic [31:0] debug_mem_status;
    logic [31:0] virt_debug_mem_data;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    int checks;
    int errors;

    debug_mem_engine #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk                  (i_clk),
        .i_rst_n                (i_rst_n),
        .debug_mem_addr         (debug_mem_addr),
        .debug_mem_data         (debug_mem_data),
        .debug_mem_write_access (debug_mem_write_access),
        .i_status_clr           (i_status_clr),
        .debug_mem_status       (debug_mem_status),
        .virt_debug_mem_data    (virt_debug_mem_data),
        .o_mem_req              (o_mem_req),
        .o_mem_we               (o_mem_we),
        .o_mem_addr             (o_mem_addr),
        .o_mem_wdata            (o_mem_wdata),
        .i_mem_ack              (i_mem_ack),
        .i_mem_rdata            (i_mem_rdata)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         pq[$];          // writes waiting for the engine (capacity 1)
    logic        m_busy;
    logic        m_wr;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_virt;
    logic [31:0] m_last;
    logic        m_rdflag;
    logic        m_done;
    logic        m_to;
    logic        m_ov;
    int          m_high;         // cycles the current request has been visible
    int          m_ops;

    function automatic void m_start(input logic wr, input logic [31:0] a, input logic [31:0] d);
        m_busy = 1'b1;
        m_wr   = wr;
        m_addr = a;
        if (wr) m_wdata = d;
        m_high = 1;
        m_done = 1'b0;
    endfunction

    initial begin : model_and_compare
        logic want_rd;
        logic set_to;
        logic set_ov;
        wr_t  w;
        pq.delete();
        m_busy = 0; m_wr = 0; m_addr = 0; m_wdata = 0; m_virt = 0; m_last = 0;
        m_rdflag = 0; m_done = 0; m_to = 0; m_ov = 0; m_high = 0; m_ops = 0;
        forever begin
            @(posedge i_clk);
            #1;
            if (!i_rst_n) begin
                pq.delete();
                m_busy = 0; m_wr = 0; m_addr = 0; m_wdata = 0; m_virt = 0;
                m_rdflag = 0; m_done = 0; m_to = 0; m_ov = 0; m_high = 0; m_ops = 0;
                m_last = debug_mem_addr;
            end else begin
                set_to  = 1'b0;
                set_ov  = 1'b0;
                want_rd = m_rdflag || (debug_mem_addr != m_last);
                m_last  = debug_mem_addr;
                if (!m_busy) begin
                    if (debug_mem_write_access) begin
                        m_start(1'b1, debug_mem_addr, debug_mem_data);
                    end else if (pq.size() > 0) begin
                        w = pq.pop_front();
                        m_start(1'b1, w.a, w.d);
                    end else if (want_rd) begin
                        m_start(1'b0, debug_mem_addr, 32'd0);
                        want_rd = 1'b0;
                    end
                end else begin
                    if (debug_mem_write_access) begin
                        if (pq.size() == 0) begin
                            w.a = debug_mem_addr;
                            w.d = debug_mem_data;
                            pq.push_back(w);
                        end else begin
                            set_ov = 1'b1;
                        end
                    end
                    if (i_mem_ack) begin
                        m_busy = 1'b0;
                        m_virt = m_wr ? m_wdata : i_mem_rdata;
                        m_done = 1'b1;
                        m_ops  = (m_ops + 1) % 256;
                        $display("txn %s addr=%h data=%h ops=%0d", m_wr ? "write" : "read ",
                                 m_addr, m_virt, m_ops);
                    end else if (m_high == TO) begin
                        m_busy = 1'b0;
                        set_to = 1'b1;
                        $display("txn timeout addr=%h", m_addr);
                    end else begin
                        m_high++;
                    end
                end
                m_rdflag = want_rd;
                if (i_status_clr) begin
                    m_to = 1'b0;
                    m_ov = 1'b0;
                end
                if (set_to) m_to = 1'b1;
                if (set_ov) m_ov = 1'b1;
            end
            chk("cyc_req",   32'(o_mem_req), 32'(m_busy));
            chk("cyc_we",    32'(o_mem_we),  32'(m_busy & m_wr));
            chk("cyc_addr",  o_mem_addr,  m_addr);
            chk("cyc_wdata", o_mem_wdata, m_wdata);
            chk("cyc_virt",  virt_debug_mem_data, m_virt);
            chk("cyc_status", debug_mem_status,
                {16'h0000, 8'(m_ops), 2'b00, m_rdflag, (pq.size() != 0), m_ov, m_to, m_done, m_busy});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic wait_req(input string nm);
        int n;
        n = 0;
        while (!o_mem_req && n < 50) begin
            tick();
            n++;
        end
        chk(nm, 32'(o_mem_req), 32'd1);
    endtask

    task automatic do_ack(input logic [31:0] rd, input int delay);
        repeat (delay) tick();
        i_mem_ack   = 1'b1;
        i_mem_rdata = rd;
        tick();
        i_mem_ack   = 1'b0;
    endtask

    task automatic strobe(input logic [31:0] d);
        debug_mem_data         = d;
        debug_mem_write_access = 1'b1;
        tick();
        debug_mem_write_access = 1'b0;
    endtask

    initial begin : driver
        int n;
        checks = 0;
        errors = 0;
        i_rst_n = 0; debug_mem_addr = 0; debug_mem_data = 0; debug_mem_write_access = 0;
        i_status_clr = 0; i_mem_ack = 0; i_mem_rdata = 0;
        repeat (3) tick();
        chk("rst_status", debug_mem_status, 32'd0);
        chk("rst_req", 32'(o_mem_req), 32'd0);
        // Address moves during reset: no read on release.
        debug_mem_addr = 32'h33;
        tick();
        i_rst_n = 1'b1;
        tick();
        tick();
        chk("rel_no_read", 32'(o_mem_req), 32'd0);
        chk("rel_status", debug_mem_status, 32'd0);

        // Single write, ack three cycles later; address change queues a read.
        debug_mem_addr = 32'h10;
        strobe(32'hA5A5A5A5);
        chk("w1_req", 32'(o_mem_req), 32'd1);
        chk("w1_we", 32'(o_mem_we), 32'd1);
        chk("w1_addr", o_mem_addr, 32'h10);
        do_ack(32'h0, 2);
        chk("w1_virt", virt_debug_mem_data, 32'hA5A5A5A5);
        chk("w1_done", 32'(debug_mem_status[1]), 32'd1);
        chk("w1_cnt", 32'(debug_mem_status[15:8]), 32'd1);
        chk("w1_rdpend", 32'(debug_mem_status[5]), 32'd1);
        wait_req("r1_req");
        chk("r1_we", 32'(o_mem_we), 32'd0);
        do_ack(32'h0BADF00D, 1);
        chk("r1_virt", virt_debug_mem_data, 32'h0BADF00D);

        // Address 0 -> 0x20 triggers a read at 0x20.
        debug_mem_addr = 32'h0;
        wait_req("r0_req");
        do_ack(32'h0, 0);
        tick();
        debug_mem_addr = 32'h20;
        tick();
        chk("r20_req", 32'(o_mem_req), 32'd1);
        chk("r20_we", 32'(o_mem_we), 32'd0);
        chk("r20_addr", o_mem_addr, 32'h20);
        do_ack(32'h12345678, 2);
        chk("r20_virt", virt_debug_mem_data, 32'h12345678);

        // Three strobes: one issued, one queued, one dropped.
        debug_mem_data = 32'd1;
        debug_mem_write_access = 1'b1;
        tick();
        debug_mem_data = 32'd2;
        tick();
        debug_mem_data = 32'd3;
        tick();
        debug_mem_write_access = 1'b0;
        chk("ovf_set", 32'(debug_mem_status[3]), 32'd1);
        chk("ovf_pend", 32'(debug_mem_status[4]), 32'd1);
        do_ack(32'h0, 0);
        chk("ovf_gap", 32'(o_mem_req), 32'd0);
        tick();
        chk("ovf_q_req", 32'(o_mem_req), 32'd1);
        chk("ovf_q_data", o_mem_wdata, 32'd2);
        do_ack(32'h0, 1);
        chk("ovf_hold", 32'(debug_mem_status[3]), 32'd1);
        i_status_clr = 1'b1;
        tick();
        i_status_clr = 1'b0;
        chk("ovf_clr", 32'(debug_mem_status[3]), 32'd0);

        // Never ack: request visible exactly TO cycles.
        strobe(32'h55);
        n = 0;
        while (o_mem_req && n < 40) begin
            n++;
            tick();
        end
        chk("to_cycles", 32'(n), 32'd8);
        chk("to_bits", 32'(debug_mem_status[2:0]), 32'b100);
        chk("to_virt", virt_debug_mem_data, 32'd2);
        i_status_clr = 1'b1;
        tick();
        i_status_clr = 1'b0;
        chk("to_clr", 32'(debug_mem_status[2]), 32'd0);

        // Ack on the last allowed cycle beats the timeout.
        strobe(32'h66);
        do_ack(32'h0, 7);
        chk("late_bits", 32'(debug_mem_status[2:0]), 32'b010);

        // Address change with strobe: write first, read afterwards.
        debug_mem_addr = 32'h40;
        strobe(32'h77);
        chk("wr_first_we", 32'(o_mem_we), 32'd1);
        chk("wr_first_addr", o_mem_addr, 32'h40);
        do_ack(32'h0, 1);
        tick();
        chk("rd_second_req", 32'(o_mem_req), 32'd1);
        chk("rd_second_we", 32'(o_mem_we), 32'd0);
        do_ack(32'hCAFEF00D, 0);
        chk("rd_second_virt", virt_debug_mem_data, 32'hCAFEF00D);

        // Reset in the middle of a read; late ack ignored.
        tick();
        debug_mem_addr = 32'h80;
        tick();
        chk("mid_rd_req", 32'(o_mem_req), 32'd1);
        i_rst_n = 1'b0;
        tick();
        chk("mid_rst_req", 32'(o_mem_req), 32'd0);
        chk("mid_rst_addr", o_mem_addr, 32'd0);
        chk("mid_rst_virt", virt_debug_mem_data, 32'd0);
        chk("mid_rst_status", debug_mem_status, 32'd0);
        i_rst_n = 1'b1;
        do_ack(32'hDEADBEEF, 0);
        tick();
        chk("late_ack_req", 32'(o_mem_req), 32'd0);
        chk("late_ack_virt", virt_debug_mem_data, 32'd0);
        chk("late_ack_status", debug_mem_status, 32'd0);

        // Completed-op count wraps after 256.
        for (int i = 0; i < 257; i++) begin
            strobe(32'(i));
            do_ack(32'h0, 0);
            tick();
        end
        chk("wrap_cnt", 32'(debug_mem_status[15:8]), 32'd1);
        chk("wrap_virt", virt_debug_mem_data, 32'd256);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
